// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, widths and helper function for the
// reset sequencer and its button debouncer.
package reset_seq_pkg;

  // Sequencer states; encoding is fixed so it can be probed on a debugger.
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    PRESS = 2'd2
  } seq_state_e;

  // Width of the press counter output.
  localparam int unsigned PRESS_CNT_W = 8;

  // Bits needed to hold the values 0..v-1; never less than one bit so a
  // degenerate count of 1 still yields a legal vector.
  function automatic int clog2(input int unsigned v);
    int unsigned x;
    int          r;
    x = (v > 1) ? (v - 1) : 0;
    r = 0;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises the raw active-low button into clk and, when
// RESET_SEQ_DEBOUNCE_EN is defined, filters it through a stability counter.
// Without the macro the stable level is the synchroniser output directly.
module btn_debounce
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 240000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic btn_pressed_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;

  // Multi-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef RESET_SEQ_DEBOUNCE_EN
  localparam int unsigned DCW = clog2(DEB_CYCLES);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  logic           stable_q, stable_d;
  logic [DCW-1:0] deb_cnt_q, deb_cnt_d;

  // Count consecutive cycles of disagreement; flip on the last one.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (synced != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d  = synced;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Stable level and debounce counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q  <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign stable = stable_q;
`else
  // Filter not built: the depth parameter has no effect here.
  logic unused_deb_cycles;
  assign unused_deb_cycles = (DEB_CYCLES != 0);
  assign stable            = synced;
`endif

  assign btn_pressed_o = ~stable;

endmodule

// File: rtl/reset_seq.sv
// reset_seq: board-level reset sequencer. Holds the downstream core in reset
// until the PLL has been locked for HOLD_CYCLES, and while the user button is
// held. Also reports a debounced button level, a press pulse and a press count.
// Optional feature: define RESET_SEQ_DEBOUNCE_EN to build the button filter.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = 240000,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   btn_n,
  output logic                   rst_out,
  output logic                   btn_pressed,
  output logic                   press_pulse,
  output logic [PRESS_CNT_W-1:0] press_cnt
);

  localparam int unsigned HCW = clog2(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  seq_state_e             state_q, state_d;
  logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
  logic                   rst_out_q;
  logic                   pressed_w;
  logic                   pressed_dly_q;
  logic                   press_pulse_q, press_pulse_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;

  btn_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_btn (
    .clk           (clk),
    .reset         (reset),
    .btn_n_i       (btn_n),
    .btn_pressed_o (pressed_w)
  );

  // Next-state and hold counter: a press wins in HOLD and RUN; any exit to
  // HOLD restarts the full hold count.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      HOLD: begin
        if (pressed_w) begin
          state_d    = PRESS;
          hold_cnt_d = '0;
        end else if (!pll_locked) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (pressed_w) begin
          state_d    = PRESS;
          hold_cnt_d = '0;
        end else if (!pll_locked) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      PRESS: begin
        if (!pressed_w) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Rising-edge detect on the debounced level feeds both pulse and counter,
  // so the count is visible in the same cycle as the pulse.
  always_comb begin
    press_pulse_d = pressed_w & ~pressed_dly_q;
    press_cnt_d   = press_cnt_q;
    if (press_pulse_d) press_cnt_d = press_cnt_q + 1'b1;
  end

  // Sequencer registers; rst_out is registered from the next state so it
  // changes on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      rst_out_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_out_q  <= (state_d != RUN);
    end
  end

  // Press edge detector and wrapping press counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pressed_dly_q <= 1'b0;
      press_pulse_q <= 1'b0;
      press_cnt_q   <= '0;
    end else begin
      pressed_dly_q <= pressed_w;
      press_pulse_q <= press_pulse_d;
      press_cnt_q   <= press_cnt_d;
    end
  end

  assign rst_out     = rst_out_q;
  assign btn_pressed = pressed_w;
  assign press_pulse = press_pulse_q;
  assign press_cnt   = press_cnt_q;

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of button synchroniser flops (min 2).
REQ-002 Parameter DEB_CYCLES, default 240000, cycles a changed button level must stay stable before acceptance (min 2).
REQ-003 Parameter HOLD_CYCLES, default 1024, cycles rst_out is held after all release conditions are met (min 1).
REQ-004 clk  in  1  single system clock (PLL output); all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high block reset.
REQ-006 pll_locked  in  1  PLL lock status, synchronous to clk.
REQ-007 btn_n  in  1  raw active-low user button, asynchronous to clk.
REQ-008 rst_out  out  1  registered active-high synchronous reset for the downstream core.
REQ-009 btn_pressed  out  1  debounced button level, 1 = pressed.
REQ-010 press_pulse  out  1  one-cycle pulse on each debounced press edge.
REQ-011 press_cnt  out  8  count of debounced presses since reset.

Function
REQ-012 btn_n SHALL pass through SYNC_STAGES flops before any other use; the synchroniser resets to 1 (released).
REQ-013 The debouncer SHALL hold a stable level and a counter; counter clears whenever the synced input equals the stable level.
REQ-014 When the synced input differs from the stable level for DEB_CYCLES consecutive cycles, the stable level SHALL flip and the counter SHALL clear in that same cycle.
REQ-015 A glitch shorter than DEB_CYCLES cycles SHALL never change btn_pressed.
REQ-016 btn_pressed SHALL equal the inverted stable level.
REQ-017 press_pulse SHALL assert for exactly one cycle, on the cycle after btn_pressed rises; releases produce no pulse.
REQ-018 press_cnt SHALL increment by 1 on each press_pulse and wrap from 255 to 0.
REQ-019 Sequencer states: HOLD, RUN, PRESS.
REQ-020 HOLD: counter clears while pll_locked=0; a pressed button goes to PRESS; otherwise the counter increments, and reaching HOLD_CYCLES-1 goes to RUN.
REQ-021 RUN: a pressed button goes to PRESS (takes priority); pll_locked=0 goes to HOLD with the counter cleared.
REQ-022 PRESS: a released button goes to HOLD with the counter cleared; pll_locked is ignored.
REQ-023 rst_out SHALL be a registered copy of (next state != RUN), so rst_out follows the state register with no extra delay.
REQ-024 With pll_locked=1 and no press, rst_out SHALL fall exactly HOLD_CYCLES cycles after the first clock in HOLD.
REQ-025 Loss of lock or a press in any cycle of HOLD SHALL restart the full HOLD_CYCLES count.

Reset
REQ-026 reset=1 SHALL force HOLD state, hold counter 0, debounce counter 0, stable level released, rst_out=1, btn_pressed=0, press_pulse=0, press_cnt=0.
REQ-027 reset asserted mid-hold, mid-debounce or in RUN SHALL take effect on the next edge; after release, the sequence restarts from HOLD.

Configuration
REQ-028 Macro RESET_SEQ_DEBOUNCE_EN defined: the debouncer of REQ-013..015 is built.
REQ-029 Macro RESET_SEQ_DEBOUNCE_EN undefined: the stable level equals the synchroniser output directly (zero added latency); DEB_CYCLES is ignored; all other requirements are unchanged.

Structure
REQ-030 Package reset_seq_pkg SHALL hold the state encoding (HOLD=2'd0, RUN=2'd1, PRESS=2'd2) and the counter-width function (clog2).
REQ-031 The synchroniser and debouncer SHALL be one sub-module, btn_debounce; the sequencer and press counter SHALL stay in reset_seq.

Verification (bench uses DEB_CYCLES=8, HOLD_CYCLES=4, SYNC_STAGES=2)
REQ-032 Release reset with pll_locked=1 and btn_n=1 -> rst_out falls exactly 4 cycles after HOLD entry; press_cnt=0.
REQ-033 In RUN, drive btn_n=0 for 5 cycles -> btn_pressed stays 0, rst_out stays 0, no press_pulse.
REQ-034 In RUN, hold btn_n=0 for 20 cycles -> btn_pressed=1 after 2+8 cycles, one press_pulse, press_cnt=1, rst_out=1; release for 8 stable cycles -> HOLD, then rst_out=0 4 cycles later.
REQ-035 Drop pll_locked for 1 cycle at HOLD count 3 -> counter restarts; rst_out falls 4 cycles after lock returns.
REQ-036 Apply 256 clean presses -> press_cnt wraps to 0; assert reset mid-debounce -> all outputs return to reset values on the next edge.
